// File: rtl/rbcp_wb_bridge.sv
// RBCP-to-Wishbone bridge: decodes the RBCP address into NUM_SLV windows and runs one
// pipelined single-beat WB cycle per RBCP strobe, with timeout, abort and error statistics.
module rbcp_wb_bridge #(
  parameter int         NUM_SLV   = 4,
  parameter int         WIN_AW    = 16,
  parameter int         TIMEOUT   = 255,
  parameter logic [7:0] DEAD_DATA = 8'hDE
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   RBCP_ACT,
  input  logic [31:0]            RBCP_ADDR,
  input  logic                   RBCP_WE,
  input  logic                   RBCP_RE,
  input  logic [7:0]             RBCP_WD,
  output logic [7:0]             RBCP_RD,
  output logic                   RBCP_ACK,
  output logic [WIN_AW-1:0]      WB_ADR,
  output logic [7:0]             WB_DAT_O,
  output logic                   WB_WE,
  output logic                   WB_CYC,
  output logic [NUM_SLV-1:0]     WB_STB,
  input  logic [8*NUM_SLV-1:0]   WB_DAT_I,
  input  logic [NUM_SLV-1:0]     WB_ACK,
  input  logic [NUM_SLV-1:0]     WB_ERR,
  input  logic [NUM_SLV-1:0]     WB_STALL,
  input  logic                   ERR_CLR,
  output logic [15:0]            ERR_CNT,
  output logic [31:0]            ERR_ADDR,
  output logic                   BUSY
);

  localparam int SW = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

  state_t              r_state;
  state_t              w_state_n;

  logic [31:0]         r_addr;
  logic                r_we;
  logic [7:0]          r_wd;
  logic [SW-1:0]       r_slot;
  logic [15:0]         r_tmo;
  logic [7:0]          r_rd;
  logic                r_ack;
  logic [WIN_AW-1:0]   r_wb_adr;
  logic [7:0]          r_wb_dat;
  logic                r_wb_we;
  logic                r_wb_cyc;
  logic [NUM_SLV-1:0]  r_wb_stb;
  logic [15:0]         r_err_cnt;
  logic [31:0]         r_err_addr;
  logic                r_busy;

  logic                w_req;
  logic [7:0]          w_slot8;
  logic [SW-1:0]       w_slot;
  logic [SW-1:0]       w_slot_n;
  logic                w_mapped;
  logic                w_ack_s;
  logic                w_err_s;
  logic                w_stall_s;
  logic [7:0]          w_dat_s;
  logic                w_accept;
  logic                w_tmo;
  logic                w_fail;
  logic [7:0]          w_rd_n;
  logic [31:0]         w_err_addr;
  logic [NUM_SLV-1:0]  w_stb_n;

  assign w_req      = RBCP_WE | RBCP_RE;
  assign w_slot8    = 8'(RBCP_ADDR >> WIN_AW);
  assign w_slot     = w_slot8[SW-1:0];
  assign w_mapped   = (w_slot8 < 8'(NUM_SLV)) && ((RBCP_ADDR >> (WIN_AW + 8)) == 32'd0);
  assign w_slot_n   = (r_state == S_IDLE) ? w_slot : r_slot;
  assign w_accept   = (r_state == S_WAIT) || !w_stall_s;
  assign w_tmo      = (r_tmo == 16'(TIMEOUT - 1));
  // Unmapped errors are flagged while still in IDLE, before the address is latched.
  assign w_err_addr = (r_state == S_IDLE) ? RBCP_ADDR : r_addr;

  always_comb begin
    w_ack_s   = 1'b0;
    w_err_s   = 1'b0;
    w_stall_s = 1'b0;
    w_dat_s   = 8'h00;
    for (int k = 0; k < NUM_SLV; k++) begin
      if (r_slot == SW'(k)) begin
        w_ack_s   = WB_ACK[k];
        w_err_s   = WB_ERR[k];
        w_stall_s = WB_STALL[k];
        w_dat_s   = WB_DAT_I[8*k +: 8];
      end
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_fail    = 1'b0;
    w_rd_n    = r_rd;
    case (r_state)
      S_IDLE: begin
        if (w_req) begin
          if (w_mapped) begin
            w_state_n = S_REQ;
          end else begin
            w_state_n = S_RESP;
            w_fail    = 1'b1;
            w_rd_n    = DEAD_DATA;
          end
        end
      end
      S_REQ, S_WAIT: begin
        if (!RBCP_ACT) begin
          w_state_n = S_IDLE;
        end else if (w_accept && w_err_s) begin
          w_state_n = S_RESP;
          w_fail    = 1'b1;
          w_rd_n    = DEAD_DATA;
        end else if (w_accept && w_ack_s) begin
          w_state_n = S_RESP;
          w_rd_n    = r_we ? r_wd : w_dat_s;
        end else if (w_tmo) begin
          w_state_n = S_RESP;
          w_fail    = 1'b1;
          w_rd_n    = DEAD_DATA;
        end else if ((r_state == S_REQ) && !w_stall_s) begin
          w_state_n = S_WAIT;
        end
      end
      S_RESP:  w_state_n = S_IDLE;
      default: w_state_n = S_IDLE;
    endcase
  end

  always_comb begin
    w_stb_n = '0;
    for (int k = 0; k < NUM_SLV; k++) begin
      w_stb_n[k] = (w_state_n == S_REQ) && (w_slot_n == SW'(k));
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) r_state <= S_IDLE;
    else     r_state <= w_state_n;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_addr     <= 32'd0;
      r_we       <= 1'b0;
      r_wd       <= 8'd0;
      r_slot     <= '0;
      r_tmo      <= 16'd0;
      r_rd       <= 8'd0;
      r_ack      <= 1'b0;
      r_wb_adr   <= '0;
      r_wb_dat   <= 8'd0;
      r_wb_we    <= 1'b0;
      r_wb_cyc   <= 1'b0;
      r_wb_stb   <= '0;
      r_err_cnt  <= 16'd0;
      r_err_addr <= 32'd0;
      r_busy     <= 1'b0;
    end else begin
      if ((r_state == S_IDLE) && w_req) begin
        r_addr <= RBCP_ADDR;
        r_we   <= RBCP_WE;
        r_wd   <= RBCP_WD;
        r_slot <= w_slot;
        if (w_mapped) begin
          r_wb_adr <= RBCP_ADDR[WIN_AW-1:0];
          r_wb_dat <= RBCP_WD;
          r_wb_we  <= RBCP_WE;
        end
      end
      if ((r_state == S_REQ) || (r_state == S_WAIT)) r_tmo <= r_tmo + 16'd1;
      else                                           r_tmo <= 16'd0;
      r_ack    <= (w_state_n == S_RESP);
      if (w_state_n == S_RESP) r_rd <= w_rd_n;
      r_wb_cyc <= (w_state_n == S_REQ) || (w_state_n == S_WAIT);
      r_wb_stb <= w_stb_n;
      r_busy   <= (w_state_n != S_IDLE);
      if (ERR_CLR)                            r_err_cnt <= w_fail ? 16'd1 : 16'd0;
      else if (w_fail && (r_err_cnt != 16'hFFFF)) r_err_cnt <= r_err_cnt + 16'd1;
      if (w_fail) r_err_addr <= w_err_addr;
    end
  end

  assign RBCP_RD  = r_rd;
  assign RBCP_ACK = r_ack;
  assign WB_ADR   = r_wb_adr;
  assign WB_DAT_O = r_wb_dat;
  assign WB_WE    = r_wb_we;
  assign WB_CYC   = r_wb_cyc;
  assign WB_STB   = r_wb_stb;
  assign ERR_CNT  = r_err_cnt;
  assign ERR_ADDR = r_err_addr;
  assign BUSY     = r_busy;

endmodule
